aux_uart_bridge: RTL and testbench
==================================

AUX_UART_BRIDGE -- requirements
Module: aux_uart_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'hFF00: aux address of register 0; registers occupy BASE_ADDR..BASE_ADDR+2.
REQ-002 SHALL have parameter FIFO_AW, default 3: log2 of the depth of each FIFO, giving a depth of 8.
REQ-003 SHALL have clk  input  1: single clock; all logic is on its rising edge.
REQ-004 SHALL have rst  input  1: asynchronous, active-high reset.
REQ-005 SHALL have aux_adr_i  input  16: aux bus address from the CPU.
REQ-006 SHALL have aux_dat_i  input  8: aux write data.
REQ-007 SHALL have aux_dat_o  output  8: aux read data.
REQ-008 SHALL have aux_we_i  input  1: write strobe, one write per cycle while high.
REQ-009 SHALL have aux_re_i  input  1: read strobe.
REQ-010 SHALL have m_axis_tdata/tvalid/tready  output 8/output 1/input 1: TX byte stream to the UART input_axis port.
REQ-011 SHALL have s_axis_tdata/tvalid/tready  input 8/input 1/output 1: RX byte stream from the UART output_axis port.
REQ-012 SHALL have irq_o  output  1: level interrupt to the CPU int0 input.

Function
REQ-013 SHALL implement the register map: +0 DATA (write = push TX FIFO; read = head of RX FIFO, and pops it), +1 STATUS (read-only), +2 CTRL.
REQ-014 SHALL define STATUS as {2'b0, tx_ovf, rx_ovf, tx_full, tx_empty, rx_full, rx_empty}, MSB first.
REQ-015 SHALL drive aux_dat_o combinationally from aux_adr_i; unmapped or non-matching addresses read 8'h00.
REQ-016 SHALL pop the RX FIFO exactly once per DATA read, on the first cycle aux_re_i is high with a DATA address (rising-edge detect on the registered strobe), regardless of how long the strobe is held.
REQ-017 SHALL return 8'h00 and pop nothing on a DATA read while RX is empty.
REQ-018 SHALL push aux_dat_i into the TX FIFO on each clk with aux_we_i high and a DATA address; when TX is full the byte is dropped and tx_ovf is set.
REQ-019 SHALL present the TX head on m_axis with tvalid = !tx_empty; the head is popped on the cycle tvalid && tready, with zero-bubble back-to-back transfer.
REQ-020 SHALL drive s_axis_tready = !rx_full; accept on tvalid && tready; rx_ovf sets on the cycle s_axis_tvalid is high while RX is full.
REQ-021 SHALL let a push and a pop in the same cycle on the same FIFO both take effect with count unchanged, including when the FIFO is full (TX: CPU write and AXI pop, no overflow) or empty (CPU pop returns 00, push takes effect).
REQ-022 SHALL wrap read and write pointers modulo 2^FIFO_AW and track full/empty with an extra pointer MSB, not a separate counter.
REQ-023 SHALL clear overflow flags by writing 1 to CTRL bit 7 (rx_ovf) or bit 6 (tx_ovf); a set event in the same cycle as the clear wins.
REQ-024 SHALL make the TX latency from the aux write cycle to m_axis_tvalid high exactly 1 clk.

Reset
REQ-025 SHALL on rst empty both FIFOs and clear pointers, overflow flags, CTRL and the strobe-edge register.
REQ-026 SHALL hold these output values during reset: m_axis_tvalid=0, s_axis_tready=0, irq_o=0, aux_dat_o=00 except for STATUS reads, which return 8'h05.
REQ-027 SHALL treat reset mid-transfer as discarding all FIFO contents, with no partial byte re-emitted after release.

Configuration
REQ-028 SHALL, with `AUX_UART_BRIDGE_IRQ_EN defined, implement CTRL bit 0 rx_ie and bit 1 tx_ie (read/write) and drive irq_o = (rx_ie & !rx_empty) | (tx_ie & tx_empty) | rx_ovf | tx_ovf, registered with 1 clk latency.
REQ-029 SHALL, without that macro, tie irq_o to 0, make CTRL bits 1:0 read 0 and ignore writes to them; overflow clear still functions.

Verification
REQ-030 SHALL cover: after reset, read BASE+1 -> 8'h05; m_axis_tvalid=0.
REQ-031 SHALL cover: write 8'h41 to BASE+0 with tready=1 -> m_axis_tdata=41, tvalid high exactly 1 clk later for 1 cycle; STATUS returns to 05.
REQ-032 SHALL cover: tready=0, 9 writes of 00..08 -> STATUS tx_full=1 and tx_ovf=1; release tready -> 00..07 emitted in order, 08 absent; write CTRL 8'h40 -> tx_ovf=0.
REQ-033 SHALL cover: inject 8'h5A on s_axis, then hold aux_re_i at BASE+0 for 3 cycles -> read 5A, exactly one pop, rx_empty=1 afterwards.
REQ-034 SHALL cover: RX full with 8 bytes, simultaneous DATA read and s_axis_tvalid -> head returned, new byte accepted, rx_full stays 1, rx_ovf stays 0.
REQ-035 SHALL cover, with the macro defined: write CTRL 8'h01, inject a byte -> irq_o high within 2 clk, low 1 clk after the byte is read.

Source files
------------

// File: rtl/aux_uart_bridge.sv
// Aux-bus register bridge to an AXI-stream UART: DATA/STATUS/CTRL registers over 2^FIFO_AW-deep TX/RX byte FIFOs.
// Optional interrupt enables and irq_o are built only with `AUX_UART_BRIDGE_IRQ_EN; otherwise irq_o is tied low.

module aux_uart_bridge_fifo #(
  parameter int AW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int DEPTH = 1 << AW;

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;

  // Caller qualifies push/pop; the extra pointer MSB separates full from empty.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i) wr_d = wr_q + 1'b1;
    if (pop_i)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= dat_i;
  end

  assign dat_o   = mem_q[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
endmodule

module aux_uart_bridge #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          FIFO_AW   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aux_adr_i,
  input  logic [7:0]  aux_dat_i,
  output logic [7:0]  aux_dat_o,
  input  logic        aux_we_i,
  input  logic        aux_re_i,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        irq_o
);
  localparam logic [15:0] ADR_DATA = BASE_ADDR;
  localparam logic [15:0] ADR_STAT = BASE_ADDR + 16'd1;
  localparam logic [15:0] ADR_CTRL = BASE_ADDR + 16'd2;

  logic       sel_data, sel_stat, sel_ctrl, ctrl_wr;
  logic       tx_full, tx_empty, tx_push, tx_pop, tx_push_req;
  logic       rx_full, rx_empty, rx_push, rx_pop, rx_pop_req;
  logic [7:0] tx_head, rx_head;
  logic       re_q, re_d;
  logic       tx_ovf_q, tx_ovf_d;
  logic       rx_ovf_q, rx_ovf_d;
  logic [7:0] status;
  logic [7:0] ctrl_rd;

  assign sel_data = (aux_adr_i == ADR_DATA);
  assign sel_stat = (aux_adr_i == ADR_STAT);
  assign sel_ctrl = (aux_adr_i == ADR_CTRL);
  assign ctrl_wr  = aux_we_i & sel_ctrl;

  // TX: a write into a full FIFO still lands if the stream drains a byte in the same cycle.
  assign tx_pop      = m_axis_tvalid & m_axis_tready;
  assign tx_push_req = aux_we_i & sel_data;
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);

  // RX pop fires once per read strobe; a pop frees a slot for a same-cycle stream beat.
  assign rx_pop_req    = aux_re_i & sel_data & ~re_q;
  assign rx_pop        = rx_pop_req & ~rx_empty;
  assign s_axis_tready = ~rst & (~rx_full | rx_pop);
  assign rx_push       = s_axis_tvalid & s_axis_tready;

  aux_uart_bridge_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .dat_i   (aux_dat_i),
    .dat_o   (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  aux_uart_bridge_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .dat_i   (s_axis_tdata),
    .dat_o   (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  assign m_axis_tvalid = ~rst & ~tx_empty;
  assign m_axis_tdata  = tx_head;

  always_comb begin
    re_d     = aux_re_i & sel_data;
    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;
    if (ctrl_wr && aux_dat_i[6]) tx_ovf_d = 1'b0;
    if (ctrl_wr && aux_dat_i[7]) rx_ovf_d = 1'b0;
    if (tx_push_req && tx_full && !tx_pop)      tx_ovf_d = 1'b1;
    if (s_axis_tvalid && rx_full && !rx_pop)    rx_ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_q     <= 1'b0;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
    end else begin
      re_q     <= re_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
    end
  end

`ifdef AUX_UART_BRIDGE_IRQ_EN
  logic [1:0] ie_q, ie_d;
  logic       irq_q, irq_d;

  always_comb begin
    ie_d  = ie_q;
    if (ctrl_wr) ie_d = aux_dat_i[1:0];
    irq_d = (ie_q[0] & ~rx_empty) | (ie_q[1] & tx_empty) | rx_ovf_q | tx_ovf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie_q  <= 2'b00;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

  assign ctrl_rd = {6'b000000, ie_q};
  assign irq_o   = irq_q;
`else
  assign ctrl_rd = 8'h00;
  assign irq_o   = 1'b0;
`endif

  assign status = {2'b00, tx_ovf_q, rx_ovf_q, tx_full, tx_empty, rx_full, rx_empty};

  always_comb begin
    aux_dat_o = 8'h00;
    if (rst) begin
      if (sel_stat) aux_dat_o = 8'h05;
    end else if (sel_data) begin
      aux_dat_o = rx_empty ? 8'h00 : rx_head;
    end else if (sel_stat) begin
      aux_dat_o = status;
    end else if (sel_ctrl) begin
      aux_dat_o = ctrl_rd;
    end
  end
endmodule

// File: tb/tb_aux_uart_bridge.sv
// Self-checking bench for aux_uart_bridge: directed scenarios plus a randomized run against a queue model.
`timescale 1ns/1ps
module tb_aux_uart_bridge;
  localparam logic [15:0] BASE = 16'hFF00;
  localparam logic [15:0] STAT = 16'hFF01;
  localparam logic [15:0] CTRL = 16'hFF02;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] aux_adr;
  logic [7:0]  aux_wdat, aux_rdat;
  logic        aux_we, aux_re;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tready;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  aux_uart_bridge #(.BASE_ADDR(16'hFF00), .FIFO_AW(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .aux_adr_i     (aux_adr),
    .aux_dat_i     (aux_wdat),
    .aux_dat_o     (aux_rdat),
    .aux_we_i      (aux_we),
    .aux_re_i      (aux_re),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .irq_o         (irq)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [15:0] a, output logic [7:0] d);
    aux_adr = a;
    #1;
    d = aux_rdat;
  endtask

  task automatic aux_write(input logic [15:0] a, input logic [7:0] d);
    aux_adr = a; aux_wdat = d; aux_we = 1'b1;
    cyc();
    aux_we = 1'b0;
  endtask

  task automatic aux_read(input logic [15:0] a, output logic [7:0] d);
    aux_adr = a; aux_re = 1'b1;
    #1;
    d = aux_rdat;
    cyc();
    aux_re = 1'b0;
    cyc();
  endtask

  task automatic inject(input logic [7:0] d);
    s_tdata = d; s_tvalid = 1'b1;
    cyc();
    s_tvalid = 1'b0;
  endtask

  task automatic drain_tx(input int n);
    got_q.delete();
    m_tready = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      if (m_tvalid === 1'b1) got_q.push_back(m_tdata);
      cyc();
    end
    m_tready = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1; aux_we = 0; aux_re = 0; aux_wdat = 0; aux_adr = STAT;
    s_tvalid = 1'b1; s_tdata = 8'h33; m_tready = 1'b1;
    cyc(); cyc();
    peek(STAT, d);
    n_checks++; if (d !== 8'h05) $display("FAIL reset_status_in_rst: got %h expected 05", d); else n_pass++;
    peek(BASE, d);
    n_checks++; if (d !== 8'h00) $display("FAIL reset_data_in_rst: got %h expected 00", d); else n_pass++;
    n_checks++; if (m_tvalid !== 1'b0) $display("FAIL reset_tvalid_in_rst: got %b expected 0", m_tvalid); else n_pass++;
    n_checks++; if (s_tready !== 1'b0) $display("FAIL reset_tready_in_rst: got %b expected 0", s_tready); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq_in_rst: got %b expected 0", irq); else n_pass++;
    s_tvalid = 1'b0; m_tready = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    peek(STAT, d);
    n_checks++; if (d !== 8'h05) $display("FAIL reset_status: got %h expected 05", d); else n_pass++;
    n_checks++; if (m_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b expected 0", m_tvalid); else n_pass++;
    n_checks++; if (s_tready !== 1'b1) $display("FAIL reset_s_tready: got %b expected 1", s_tready); else n_pass++;
  endtask

  task automatic test_tx_single();
    logic [7:0] d;
    m_tready = 1'b1;
    aux_adr = BASE; aux_wdat = 8'h41; aux_we = 1'b1;
    #1;
    n_checks++; if (m_tvalid !== 1'b0) $display("FAIL tx1_tvalid_early: got %b expected 0", m_tvalid); else n_pass++;
    cyc();
    aux_we = 1'b0;
    n_checks++; if (m_tvalid !== 1'b1) $display("FAIL tx1_tvalid: got %b expected 1", m_tvalid); else n_pass++;
    n_checks++; if (m_tdata !== 8'h41) $display("FAIL tx1_tdata: got %h expected 41", m_tdata); else n_pass++;
    cyc();
    n_checks++; if (m_tvalid !== 1'b0) $display("FAIL tx1_tvalid_one_cycle: got %b expected 0", m_tvalid); else n_pass++;
    peek(STAT, d);
    n_checks++; if (d !== 8'h05) $display("FAIL tx1_status: got %h expected 05", d); else n_pass++;
    m_tready = 1'b0;
  endtask

  task automatic test_tx_overflow();
    logic [7:0] d;
    m_tready = 1'b0;
    for (int i = 0; i < 9; i++) aux_write(BASE, 8'(i));
    peek(STAT, d);
    n_checks++; if (d !== 8'h29) $display("FAIL txovf_status_full: got %h expected 29", d); else n_pass++;
    drain_tx(8);
    n_checks++; if (got_q.size() !== 8) $display("FAIL txovf_count_8_cycles: got %0d expected 8", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== 8'(i)) $display("FAIL txovf_byte%0d: got %h expected %h", i, got_q[i], 8'(i)); else n_pass++;
    end
    n_checks++; if (m_tvalid !== 1'b0) $display("FAIL txovf_dropped_byte_absent: got tvalid %b expected 0", m_tvalid); else n_pass++;
    peek(STAT, d);
    n_checks++; if (d !== 8'h25) $display("FAIL txovf_status_drained: got %h expected 25", d); else n_pass++;
    aux_write(CTRL, 8'h40);
    peek(STAT, d);
    n_checks++; if (d !== 8'h05) $display("FAIL txovf_clear: got %h expected 05", d); else n_pass++;
  endtask

  task automatic test_tx_full_simul();
    logic [7:0] d;
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) aux_write(BASE, 8'h10 + 8'(i));
    peek(STAT, d);
    n_checks++; if (d !== 8'h09) $display("FAIL txsim_status_full: got %h expected 09", d); else n_pass++;
    aux_adr = BASE; aux_wdat = 8'h18; aux_we = 1'b1; m_tready = 1'b1;
    #1;
    n_checks++; if (m_tdata !== 8'h10) $display("FAIL txsim_head: got %h expected 10", m_tdata); else n_pass++;
    cyc();
    aux_we = 1'b0; m_tready = 1'b0;
    peek(STAT, d);
    n_checks++; if (d !== 8'h09) $display("FAIL txsim_status_no_ovf: got %h expected 09", d); else n_pass++;
    drain_tx(8);
    n_checks++; if (got_q.size() !== 8) $display("FAIL txsim_count: got %0d expected 8", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== 8'h11 + 8'(i)) $display("FAIL txsim_byte%0d: got %h expected %h", i, got_q[i], 8'h11 + 8'(i)); else n_pass++;
    end
  endtask

  task automatic test_rx_hold();
    logic [7:0] d;
    s_tdata = 8'h5A; s_tvalid = 1'b1;
    #1;
    n_checks++; if (s_tready !== 1'b1) $display("FAIL rxhold_tready: got %b expected 1", s_tready); else n_pass++;
    cyc();
    s_tdata = 8'h6B;
    cyc();
    s_tvalid = 1'b0;
    peek(STAT, d);
    n_checks++; if (d !== 8'h04) $display("FAIL rxhold_status: got %h expected 04", d); else n_pass++;
    aux_adr = BASE; aux_re = 1'b1;
    #1;
    n_checks++; if (aux_rdat !== 8'h5A) $display("FAIL rxhold_first: got %h expected 5A", aux_rdat); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_checks++; if (aux_rdat !== 8'h6B) $display("FAIL rxhold_held%0d: got %h expected 6B", i, aux_rdat); else n_pass++;
    end
    cyc();
    aux_re = 1'b0;
    cyc();
    aux_read(BASE, d);
    n_checks++; if (d !== 8'h6B) $display("FAIL rxhold_second_read: got %h expected 6B", d); else n_pass++;
    peek(STAT, d);
    n_checks++; if (d !== 8'h05) $display("FAIL rxhold_empty_after: got %h expected 05", d); else n_pass++;
    aux_read(BASE, d);
    n_checks++; if (d !== 8'h00) $display("FAIL rx_empty_read: got %h expected 00", d); else n_pass++;
    peek(STAT, d);
    n_checks++; if (d !== 8'h05) $display("FAIL rx_empty_read_status: got %h expected 05", d); else n_pass++;
  endtask

  task automatic test_rx_full_simul();
    logic [7:0] d;
    s_tvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_tdata = 8'h80 + 8'(i);
      #1;
      n_checks++; if (s_tready !== 1'b1) $display("FAIL rxfull_fill_tready%0d: got %b expected 1", i, s_tready); else n_pass++;
      cyc();
    end
    s_tvalid = 1'b0;
    peek(STAT, d);
    n_checks++; if (d !== 8'h06) $display("FAIL rxfull_status: got %h expected 06", d); else n_pass++;
    n_checks++; if (s_tready !== 1'b0) $display("FAIL rxfull_tready_low: got %b expected 0", s_tready); else n_pass++;
    aux_adr = BASE; aux_re = 1'b1; s_tvalid = 1'b1; s_tdata = 8'h88;
    #1;
    n_checks++; if (aux_rdat !== 8'h80) $display("FAIL rxfull_simul_head: got %h expected 80", aux_rdat); else n_pass++;
    n_checks++; if (s_tready !== 1'b1) $display("FAIL rxfull_simul_tready: got %b expected 1", s_tready); else n_pass++;
    cyc();
    aux_re = 1'b0; s_tvalid = 1'b0;
    peek(STAT, d);
    n_checks++; if (d !== 8'h06) $display("FAIL rxfull_simul_status: got %h expected 06", d); else n_pass++;
    inject(8'h99);
    peek(STAT, d);
    n_checks++; if (d !== 8'h16) $display("FAIL rxovf_set: got %h expected 16", d); else n_pass++;
    aux_adr = CTRL; aux_wdat = 8'h80; aux_we = 1'b1; s_tvalid = 1'b1;
    cyc();
    aux_we = 1'b0; s_tvalid = 1'b0;
    peek(STAT, d);
    n_checks++; if (d !== 8'h16) $display("FAIL rxovf_set_beats_clear: got %h expected 16", d); else n_pass++;
    aux_write(CTRL, 8'h80);
    peek(STAT, d);
    n_checks++; if (d !== 8'h06) $display("FAIL rxovf_clear: got %h expected 06", d); else n_pass++;
    cyc();
    for (int i = 0; i < 8; i++) begin
      aux_read(BASE, d);
      n_checks++; if (d !== 8'h81 + 8'(i)) $display("FAIL rxfull_drain%0d: got %h expected %h", i, d, 8'h81 + 8'(i)); else n_pass++;
    end
    peek(STAT, d);
    n_checks++; if (d !== 8'h05) $display("FAIL rxfull_drained_status: got %h expected 05", d); else n_pass++;
  endtask

  task automatic test_irq();
    logic [7:0] d;
`ifdef AUX_UART_BRIDGE_IRQ_EN
    bit seen;
    aux_write(CTRL, 8'h01);
    peek(CTRL, d);
    n_checks++; if (d !== 8'h01) $display("FAIL irq_ctrl_readback: got %h expected 01", d); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_idle: got %b expected 0", irq); else n_pass++;
    inject(8'h3C);
    seen = 1'b0;
    for (int k = 0; k < 2 && !seen; k++) begin
      cyc();
      if (irq === 1'b1) seen = 1'b1;
    end
    n_checks++; if (!seen) $display("FAIL irq_rx_within_2clk: got 0 expected 1"); else n_pass++;
    aux_read(BASE, d);
    n_checks++; if (d !== 8'h3C) $display("FAIL irq_rx_byte: got %h expected 3C", d); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_rx_cleared: got %b expected 0", irq); else n_pass++;
    aux_write(CTRL, 8'h02);
    cyc();
    n_checks++; if (irq !== 1'b1) $display("FAIL irq_tx_empty: got %b expected 1", irq); else n_pass++;
    aux_write(CTRL, 8'h00);
    cyc();
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_disabled: got %b expected 0", irq); else n_pass++;
`else
    aux_write(CTRL, 8'hFF);
    peek(CTRL, d);
    n_checks++; if (d !== 8'h00) $display("FAIL ctrl_ie_absent: got %h expected 00", d); else n_pass++;
    inject(8'h3C);
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_checks++; if (irq !== 1'b0) $display("FAIL irq_tied_low%0d: got %b expected 0", k, irq); else n_pass++;
    end
    aux_read(BASE, d);
    n_checks++; if (d !== 8'h3C) $display("FAIL noirq_rx_byte: got %h expected 3C", d); else n_pass++;
`endif
  endtask

  task automatic test_reset_midstream();
    logic [7:0] d;
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) aux_write(BASE, 8'hA0 + 8'(i));
    inject(8'hB0);
    inject(8'hB1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    peek(STAT, d);
    n_checks++; if (d !== 8'h05) $display("FAIL midrst_status: got %h expected 05", d); else n_pass++;
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (m_tvalid !== 1'b0) $display("FAIL midrst_no_reemit%0d: got %b expected 0", i, m_tvalid); else n_pass++;
      cyc();
    end
    m_tready = 1'b0;
    aux_read(BASE, d);
    n_checks++; if (d !== 8'h00) $display("FAIL midrst_rx_discarded: got %h expected 00", d); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] d, exp_dat, exp_stat;
    bit tx_ovf, rx_ovf, prev_re, rx_pop, tx_pop, exp_srdy;
    tx_ovf = 0; rx_ovf = 0; prev_re = 0;
    for (int c = 0; c < 600; c++) begin
      int pw, pr, ps, pt;
      if (c < 300) begin pw = 60; pt = 25; ps = 70; pr = 20; end
      else         begin pw = 25; pt = 80; ps = 25; pr = 60; end
      aux_adr  = BASE;
      aux_we   = ($urandom_range(99) < pw);
      aux_wdat = 8'($urandom);
      aux_re   = ($urandom_range(99) < pr);
      s_tvalid = ($urandom_range(99) < ps);
      s_tdata  = 8'($urandom);
      m_tready = ($urandom_range(99) < pt);
      #1;
      rx_pop   = aux_re && !prev_re && (rxq.size() > 0);
      exp_srdy = (rxq.size() < 8) || rx_pop;
      exp_dat  = (rxq.size() > 0) ? rxq[0] : 8'h00;
      n_checks++; if (m_tvalid !== (txq.size() != 0)) $display("FAIL rand_tvalid c%0d: got %b expected %b", c, m_tvalid, txq.size() != 0); else n_pass++;
      if (txq.size() != 0) begin
        n_checks++; if (m_tdata !== txq[0]) $display("FAIL rand_tdata c%0d: got %h expected %h", c, m_tdata, txq[0]); else n_pass++;
      end
      n_checks++; if (aux_rdat !== exp_dat) $display("FAIL rand_rdata c%0d: got %h expected %h", c, aux_rdat, exp_dat); else n_pass++;
      n_checks++; if (s_tready !== exp_srdy) $display("FAIL rand_s_tready c%0d: got %b expected %b", c, s_tready, exp_srdy); else n_pass++;
      tx_pop = (txq.size() != 0) && m_tready;
      if (aux_we && txq.size() == 8 && !tx_pop) tx_ovf = 1;
      if (s_tvalid && rxq.size() == 8 && !rx_pop) rx_ovf = 1;
      if (tx_pop) void'(txq.pop_front());
      if (aux_we && (txq.size() < 8)) txq.push_back(aux_wdat);
      if (rx_pop) void'(rxq.pop_front());
      if (s_tvalid && exp_srdy) rxq.push_back(s_tdata);
      prev_re = aux_re;
      cyc();
    end
    aux_we = 0; aux_re = 0; s_tvalid = 0; m_tready = 0;
    exp_stat = {2'b00, tx_ovf, rx_ovf, txq.size() == 8, txq.size() == 0, rxq.size() == 8, rxq.size() == 0};
    peek(STAT, d);
    n_checks++; if (d !== exp_stat) $display("FAIL rand_status: got %h expected %h", d, exp_stat); else n_pass++;
    drain_tx(10);
    n_checks++; if (got_q.size() !== txq.size()) $display("FAIL rand_tx_left: got %0d expected %0d", got_q.size(), txq.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < txq.size(); i++) begin
      n_checks++; if (got_q[i] !== txq[i]) $display("FAIL rand_tx_tail%0d: got %h expected %h", i, got_q[i], txq[i]); else n_pass++;
    end
    for (int i = 0; i < rxq.size(); i++) begin
      aux_read(BASE, d);
      n_checks++; if (d !== rxq[i]) $display("FAIL rand_rx_tail%0d: got %h expected %h", i, d, rxq[i]); else n_pass++;
    end
    aux_write(CTRL, 8'hC0);
    peek(STAT, d);
    n_checks++; if (d !== 8'h05) $display("FAIL rand_final_status: got %h expected 05", d); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; aux_we = 0; aux_re = 0; aux_adr = STAT; aux_wdat = 0;
    s_tvalid = 0; s_tdata = 0; m_tready = 0;
    test_reset();
    test_tx_single();
    test_tx_overflow();
    test_tx_full_simul();
    test_rx_hold();
    test_rx_full_simul();
    test_irq();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
